traffic_light_controller: RTL
=============================

# traffic_light_controller

- Sequences the intersection Timer and drives the main-street, side-street and pedestrian lamps.
- Holds the three programmable interval values (base, extension, yellow) and asserts a one-cycle `start_timer` with `parm_value` at each state entry.
- Advances state on the Timer's `expired` pulse.
- Sits between the operator switch/sensor inputs and the Timer, in the same clock domain.

## Interface
- `T_BASE_DEF`, 4'd6, reset value of base interval register
- `T_EXT_DEF`, 4'd3, reset value of extension interval register
- `T_YEL_DEF`, 4'd2, reset value of yellow interval register
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-low reset
- `side_sensor` input 1: vehicle waiting on side street (level, synchronous)
- `walk_btn` input 1: pedestrian request (level, synchronous)
- `prog_sync` input 1: write interval register and restart sequence
- `time_param_selector` input 2: 00 base, 01 ext, 10 yellow, 11 no write
- `time_value` input 4: value written on `prog_sync`
- `expired` input 1: one-cycle pulse from Timer
- `start_timer` output 1: one-cycle Timer load strobe
- `parm_value` output 4: interval for Timer; valid while `start_timer`=1
- `main_light` output 3: {R,Y,G}
- `side_light` output 3: {R,Y,G}
- `walk_light` output 1: pedestrian walk lamp

## Operation
- States and lamps:
  - INIT: main R, side R.
  - MG_BASE: main G, side R. Loads base.
  - MG_EXT: main G, side R. Loads ext.
  - MY: main Y, side R. Loads yel.
  - WALK: main R, side R, `walk_light`=1. Loads ext.
  - SG_BASE: main R, side G. Loads base.
  - SG_EXT: main R, side G. Loads ext.
  - SY: main R, side Y. Loads yel.
- `walk_pending` register:
  - Set on any cycle with `walk_btn`=1.
  - Cleared on the edge entering WALK.
  - Set wins over clear in the same cycle.
- Transitions, taken only on `expired`=1:
  - INIT -> MG_BASE unconditionally, on the first clock, without waiting for `expired`.
  - MG_BASE / MG_EXT -> MY if `side_sensor` or `walk_pending`; otherwise -> MG_EXT. MG_EXT repeats indefinitely.
  - MY -> WALK if `walk_pending`; otherwise -> SG_BASE.
  - WALK -> SG_BASE if `side_sensor`; otherwise -> MG_BASE.
  - SG_BASE -> SG_EXT if `side_sensor`; otherwise -> SY.
  - SG_EXT -> SY (at most one side extension).
  - SY -> MG_BASE.
- Every state entry registers `start_timer`=1 and `parm_value` = the destination state's register, on the same edge as the state change.
- `start_timer` is 0 in all other cycles.
- `parm_value` holds its last value when `start_timer`=0.
- Programming (`prog_sync`=1):
  - Writes `time_value` into the selected register (selector 11: no write).
  - Forces state to INIT on that edge, with `start_timer`=0.
  - The following cycle enters MG_BASE and loads the updated base value.
- Interval registers are 4-bit and unsigned; no arithmetic is performed.
- Value 0 is legal: the Timer expires immediately and the controller passes through the state in two cycles.
- `side_sensor` and `walk_btn` are sampled only in the `expired` cycle (except the `walk_pending` set, which samples every cycle).

## Timing
- Reset (asynchronous, `reset`=0):
  - State INIT, `start_timer`=0, `parm_value`=0.
  - main_light=3'b100, side_light=3'b100, `walk_light`=0, `walk_pending`=0.
  - Interval registers at their `*_DEF` values.
- First rising edge after release: MG_BASE, `start_timer`=1, `parm_value`=`T_BASE_DEF`.
- Latency: `expired` at edge k -> new state, lamps and `start_timer` all visible after edge k. No bubble cycles.
- `expired` is ignored in INIT and in any cycle where `start_timer`=1.
- `prog_sync` and `expired` in the same cycle: `prog_sync` wins.
- Reset asserted mid-interval: immediate return to reset values. The Timer is reloaded only on the post-reset MG_BASE entry.
- Lamps are registered. Exactly one lamp is lit per street per cycle, and never G/Y on both streets at once.

## Configuration
- `WALK_REQUEST_EN` defined:
  - `walk_btn`, `walk_pending` and the WALK state are implemented as above.
- `WALK_REQUEST_EN` undefined:
  - `walk_btn` is ignored, `walk_pending` is constant 0 and WALK is unreachable.
  - `walk_light` is tied 0 and MY always goes to SG_BASE.
  - Port list is unchanged.

## Test plan
- Reset release, bench Timer model expiring 5 cycles after each `start_timer`, `side_sensor`=0 -> `start_timer` with `parm_value`=6 on first edge, then repeated `parm_value`=3 (MG_EXT); main stays G.
- `side_sensor`=1 during MG_EXT expiry -> MY (`parm_value`=2), then SG_BASE (6), then SG_EXT (3), then SY (2), then MG_BASE (6); lamps match each state.
- `walk_btn` pulsed 1 cycle during MG_BASE, `side_sensor`=0 -> MY, then WALK (`walk_light`=1, `parm_value`=3), then MG_BASE; `walk_pending` cleared.
- `prog_sync`=1, selector=00, value=4'd9, in the same cycle as `expired` -> INIT for one cycle, no transition from `expired`, then MG_BASE with `parm_value`=9.
- Yellow programmed to 0, forced to MY -> MY lasts 2 cycles, then SG_BASE.
- `reset` asserted mid-SG_BASE -> outputs immediately return to reset values (both red, `start_timer`=0); first edge after release reloads base.

Source files
------------

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - intersection sequencer driving the Timer and street/pedestrian lamps
// Optional pedestrian request path is built only when WALK_REQUEST_EN is defined.
module traffic_light_controller #(
  parameter logic [3:0] T_BASE_DEF = 4'd6,
  parameter logic [3:0] T_EXT_DEF  = 4'd3,
  parameter logic [3:0] T_YEL_DEF  = 4'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_sensor,
  input  logic       walk_btn,
  input  logic       prog_sync,
  input  logic [1:0] time_param_selector,
  input  logic [3:0] time_value,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] parm_value,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light
);

`ifdef WALK_REQUEST_EN
  localparam logic WALK_EN = 1'b1;
`else
  localparam logic WALK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    INIT, MG_BASE, MG_EXT, MY, WALK, SG_BASE, SG_EXT, SY
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t     state;
  state_t     next_state;
  logic       enter;
  logic [3:0] base_reg;
  logic [3:0] ext_reg;
  logic [3:0] yel_reg;
  logic       walk_pending;
  logic       walk_req;
  logic [3:0] next_parm;
  logic [2:0] next_main;
  logic [2:0] next_side;
  logic       next_walk;

  assign walk_req = WALK_EN & walk_pending;

  // A start_timer cycle masks expired so a stale pulse cannot skip the new interval.
  always_comb begin
    next_state = state;
    enter      = 1'b0;
    if (state == INIT) begin
      next_state = MG_BASE;
      enter      = 1'b1;
    end else if (expired && !start_timer) begin
      enter = 1'b1;
      case (state)
        MG_BASE, MG_EXT: next_state = (side_sensor || walk_req) ? MY : MG_EXT;
        MY:              next_state = walk_req ? WALK : SG_BASE;
        WALK:            next_state = side_sensor ? SG_BASE : MG_BASE;
        SG_BASE:         next_state = side_sensor ? SG_EXT : SY;
        SG_EXT:          next_state = SY;
        SY:              next_state = MG_BASE;
        default:         next_state = MG_BASE;
      endcase
    end
  end

  always_comb begin
    next_parm = base_reg;
    next_main = RED;
    next_side = RED;
    next_walk = 1'b0;
    case (next_state)
      MG_BASE: begin next_parm = base_reg; next_main = GRN; end
      MG_EXT:  begin next_parm = ext_reg;  next_main = GRN; end
      MY:      begin next_parm = yel_reg;  next_main = YEL; end
      WALK:    begin next_parm = ext_reg;  next_walk = WALK_EN; end
      SG_BASE: begin next_parm = base_reg; next_side = GRN; end
      SG_EXT:  begin next_parm = ext_reg;  next_side = GRN; end
      SY:      begin next_parm = yel_reg;  next_side = YEL; end
      default: next_parm = base_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= INIT;
      start_timer  <= 1'b0;
      parm_value   <= 4'd0;
      main_light   <= RED;
      side_light   <= RED;
      walk_light   <= 1'b0;
      walk_pending <= 1'b0;
      base_reg     <= T_BASE_DEF;
      ext_reg      <= T_EXT_DEF;
      yel_reg      <= T_YEL_DEF;
    end else begin
      // A new request in the WALK-entry cycle survives the clear.
      walk_pending <= WALK_EN & (walk_btn |
                      (walk_pending & ~(enter & ~prog_sync & (next_state == WALK))));
      if (prog_sync) begin
        case (time_param_selector)
          2'b00:   base_reg <= time_value;
          2'b01:   ext_reg  <= time_value;
          2'b10:   yel_reg  <= time_value;
          default: ;
        endcase
        state       <= INIT;
        start_timer <= 1'b0;
        main_light  <= RED;
        side_light  <= RED;
        walk_light  <= 1'b0;
      end else if (enter) begin
        state       <= next_state;
        start_timer <= 1'b1;
        parm_value  <= next_parm;
        main_light  <= next_main;
        side_light  <= next_side;
        walk_light  <= next_walk;
      end else begin
        start_timer <= 1'b0;
      end
    end
  end

endmodule
